// File: rtl/tx_block.sv
// 8N1/8N2 serial transmitter with a one-entry holding register; serial_out is a flop.
// Holding register refills on the same edge it empties, so back-to-back frames have no idle gap.
module tx_block #(
    parameter int BIT_PERIOD = 286,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    input  logic       clear_error,
    output logic       serial_out,
    output logic       buffer_full,
    output logic       tx_active,
    output logic       overrun_error
);
    localparam int CW = $clog2(BIT_PERIOD);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, next_state;
    logic [7:0]    hold_reg, shift_reg, shift_next;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          stop_idx;
    logic          bit_end, stop_last, transfer, serial_d;

    assign bit_end   = (cnt == CW'(BIT_PERIOD - 1));
    assign stop_last = (STOP_BITS == 1) || stop_idx;
    assign transfer  = buffer_full && ((state == IDLE) || (state == STOP && bit_end && stop_last));
    assign tx_active = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (buffer_full) next_state = START;
            START: if (bit_end) next_state = DATA;
            DATA:  if (bit_end && bit_idx == 3'd7) next_state = STOP;
            STOP:  if (bit_end && stop_last) next_state = buffer_full ? START : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Line level is computed from the next state so the flop leads the state by zero cycles.
    always_comb begin
        shift_next = shift_reg;
        if (transfer)
            shift_next = hold_reg;
        else if (state == DATA && bit_end)
            shift_next = {1'b0, shift_reg[7:1]};
        serial_d = 1'b1;
        case (next_state)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_next[0];
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            serial_out    <= 1'b1;
            shift_reg     <= '0;
            hold_reg      <= '0;
            buffer_full   <= 1'b0;
            overrun_error <= 1'b0;
            cnt           <= '0;
            bit_idx       <= '0;
            stop_idx      <= 1'b0;
        end else begin
            serial_out <= serial_d;
            shift_reg  <= shift_next;

            if (state == IDLE || transfer || bit_end) cnt <= '0;
            else                                      cnt <= cnt + 1'b1;

            if (state == START)               bit_idx <= '0;
            else if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;

            if (state != STOP)  stop_idx <= 1'b0;
            else if (bit_end)   stop_idx <= !stop_idx;

            if (tx_load && (!buffer_full || transfer)) hold_reg <= tx_data;

            if (transfer)     buffer_full <= tx_load;
            else if (tx_load) buffer_full <= 1'b1;

            // A fresh overrun beats a simultaneous clear.
            if (tx_load && buffer_full && !transfer) overrun_error <= 1'b1;
            else if (clear_error)                    overrun_error <= 1'b0;
        end
    end
endmodule
